id_ex_stage: RTL and testbench

// - ID/EX pipeline register plus EX-side operand forwarding for the 5-stage core; it directly feeds the ALU.
// - Latches decoded operands and control (incl. ALUFun, Sign) and selects ALU A/B from the latched, EX/MEM or MEM/WB value.
// - Detects load-use hazards, drives a stall request upstream and inserts a bubble into EX.

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage_fwd_mux.sv | 32 +++
 rtl/id_ex_stage.sv | 114 +++++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register and its forwarding muxes.
package id_ex_stage_pkg;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_LT  = 6'b110101;

  localparam logic SRC1_RS    = 1'b0;
  localparam logic SRC1_SHAMT = 1'b1;
  localparam logic SRC2_RT    = 1'b0;
  localparam logic SRC2_IMM   = 1'b1;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, bypass and EX-side signals of the ID/EX stage, grouped for port connection.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              stall_i;
  logic              flush_i;
  logic              id_valid;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm32;
  logic [4:0]        id_shamt;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [5:0]        id_ALUFun;
  logic              id_Sign;
  logic              id_ALUSrc1;
  logic              id_ALUSrc2;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic              id_MemWrite;
  logic              exmem_RegWrite;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_result;
  logic              memwb_RegWrite;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_result;
  logic              ex_valid;
  logic [DATA_W-1:0] ALU_A;
  logic [DATA_W-1:0] ALU_B;
  logic [5:0]        ALUFun;
  logic              Sign;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_RegWrite;
  logic              ex_MemRead;
  logic              ex_MemWrite;
  logic              load_use_o;

  modport master (
    output stall_i, flush_i, id_valid, id_rs_data, id_rt_data, id_imm32, id_shamt,
           id_rs, id_rt, id_rd, id_ALUFun, id_Sign, id_ALUSrc1, id_ALUSrc2,
           id_RegWrite, id_MemRead, id_MemWrite,
           exmem_RegWrite, exmem_rd, exmem_result, memwb_RegWrite, memwb_rd, memwb_result,
    input  ex_valid, ALU_A, ALU_B, ALUFun, Sign, ex_store_data, ex_rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, load_use_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid, id_rs_data, id_rt_data, id_imm32, id_shamt,
           id_rs, id_rt, id_rd, id_ALUFun, id_Sign, id_ALUSrc1, id_ALUSrc2,
           id_RegWrite, id_MemRead, id_MemWrite,
           exmem_RegWrite, exmem_rd, exmem_result, memwb_RegWrite, memwb_rd, memwb_result,
    output ex_valid, ALU_A, ALU_B, ALUFun, Sign, ex_store_data, ex_rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, load_use_o
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand EX forwarding: EX/MEM beats MEM/WB beats the latched value; r0 never forwards.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_lat_data,
  input  logic              i_exmem_we,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_data,
  input  logic              i_memwb_we,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_data,
  output logic [DATA_W-1:0] o_data
);
  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_we && (i_exmem_rd != REG_AW'(REG_ZERO)) && (i_exmem_rd == i_addr);
  assign w_memwb_hit = i_memwb_we && (i_memwb_rd != REG_AW'(REG_ZERO)) && (i_memwb_rd == i_addr);

  always_comb begin
    o_data = i_lat_data;
    if (w_exmem_hit) begin
      o_data = i_exmem_data;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_data;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  ctrl_t             r_ctrl;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm32;
  logic [4:0]        r_shamt;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [5:0]        r_alufun;
  logic              r_sign;
  logic              r_alusrc1;
  logic              r_alusrc2;

  logic              w_wb_ok;
  logic              w_load_use;
  logic [DATA_W-1:0] w_cap_rs;
  logic [DATA_W-1:0] w_cap_rt;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  assign w_wb_ok = bus.memwb_RegWrite && (bus.memwb_rd != REG_AW'(REG_ZERO));

  // Register file reads are not write-bypassed, so the WB write is folded in at capture.
  assign w_cap_rs = (w_wb_ok && bus.memwb_rd == bus.id_rs) ? bus.memwb_result : bus.id_rs_data;
  assign w_cap_rt = (w_wb_ok && bus.memwb_rd == bus.id_rt) ? bus.memwb_result : bus.id_rt_data;

  assign w_load_use = !bus.stall_i && r_ctrl.valid && r_ctrl.mem_read &&
                      (r_rd != REG_AW'(REG_ZERO)) && bus.id_valid &&
                      ((r_rd == bus.id_rs) || (r_rd == bus.id_rt));

  always_ff @(posedge clk) begin
    if (reset || (!bus.stall_i && (bus.flush_i || w_load_use))) begin
      r_ctrl    <= BUBBLE_CTRL;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm32   <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_alufun  <= ALU_ADD;
      r_sign    <= 1'b0;
      r_alusrc1 <= SRC1_RS;
      r_alusrc2 <= SRC2_RT;
    end else if (bus.stall_i) begin
      // Held operands would otherwise miss a writeback that retires during the stall.
      if (w_wb_ok && bus.memwb_rd == r_rs) r_rs_data <= bus.memwb_result;
      if (w_wb_ok && bus.memwb_rd == r_rt) r_rt_data <= bus.memwb_result;
    end else begin
      r_ctrl.valid     <= bus.id_valid;
      r_ctrl.reg_write <= bus.id_RegWrite;
      r_ctrl.mem_read  <= bus.id_MemRead;
      r_ctrl.mem_write <= bus.id_MemWrite;
      r_rs_data        <= w_cap_rs;
      r_rt_data        <= w_cap_rt;
      r_imm32          <= bus.id_imm32;
      r_shamt          <= bus.id_shamt;
      r_rs             <= bus.id_rs;
      r_rt             <= bus.id_rt;
      r_rd             <= bus.id_rd;
      r_alufun         <= bus.id_ALUFun;
      r_sign           <= bus.id_Sign;
      r_alusrc1        <= bus.id_ALUSrc1;
      r_alusrc2        <= bus.id_ALUSrc2;
    end
  end

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .i_addr       (r_rs),
    .i_lat_data   (r_rs_data),
    .i_exmem_we   (bus.exmem_RegWrite),
    .i_exmem_rd   (bus.exmem_rd),
    .i_exmem_data (bus.exmem_result),
    .i_memwb_we   (bus.memwb_RegWrite),
    .i_memwb_rd   (bus.memwb_rd),
    .i_memwb_data (bus.memwb_result),
    .o_data       (w_fwd_rs)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .i_addr       (r_rt),
    .i_lat_data   (r_rt_data),
    .i_exmem_we   (bus.exmem_RegWrite),
    .i_exmem_rd   (bus.exmem_rd),
    .i_exmem_data (bus.exmem_result),
    .i_memwb_we   (bus.memwb_RegWrite),
    .i_memwb_rd   (bus.memwb_rd),
    .i_memwb_data (bus.memwb_result),
    .o_data       (w_fwd_rt)
  );

  assign bus.ALU_A         = (r_alusrc1 == SRC1_SHAMT) ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign bus.ALU_B         = (r_alusrc2 == SRC2_IMM) ? r_imm32 : w_fwd_rt;
  assign bus.ex_store_data = w_fwd_rt;
  assign bus.ex_valid      = r_ctrl.valid;
  assign bus.ex_RegWrite   = r_ctrl.reg_write;
  assign bus.ex_MemRead    = r_ctrl.mem_read;
  assign bus.ex_MemWrite   = r_ctrl.mem_write;
  assign bus.ex_rd         = r_rd;
  assign bus.ALUFun        = r_alufun;
  assign bus.Sign          = r_sign;
  assign bus.load_use_o    = w_load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench: driver pushes model-predicted EX outputs, negedge monitor pops and compares.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct {
    logic        reset, stall, flush, idv;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [5:0]  fun;
    logic        sign, s1, s2, rw, mr, mw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
  } in_t;

  // The instruction sitting in EX, as the model sees it.
  typedef struct {
    logic        valid;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  shamt, rs, rt, rd;
    logic [5:0]  fun;
    logic        sign, s1, s2, rw, mr, mw;
  } ex_t;

  typedef struct {
    logic        valid, sign, rw, mr, mw, lu;
    logic [31:0] a, b, store;
    logic [5:0]  fun;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  ex_t  m;
  logic m_known = 1'b0;

  function automatic logic writes(logic we, logic [4:0] rd, logic [4:0] a);
    return we && rd != 5'd0 && rd == a;
  endfunction

  function automatic logic [31:0] fwd(in_t x, logic [4:0] a, logic [31:0] lat);
    if (writes(x.xw, x.xrd, a)) return x.xres;
    if (writes(x.ww, x.wrd, a)) return x.wres;
    return lat;
  endfunction

  function automatic logic lu_of(ex_t s, in_t x);
    return !x.stall && s.valid && s.mr && s.rd != 5'd0 && x.idv &&
           (s.rd == x.rs || s.rd == x.rt);
  endfunction

  function automatic exp_t expect_of(ex_t s, in_t x);
    exp_t e;
    e.valid = s.valid; e.sign = s.sign; e.rw = s.rw; e.mr = s.mr; e.mw = s.mw;
    e.fun = s.fun; e.rd = s.rd;
    e.store = fwd(x, s.rt, s.rtd);
    e.a = s.s1 ? {27'd0, s.shamt} : fwd(x, s.rs, s.rsd);
    e.b = s.s2 ? s.imm : e.store;
    e.lu = lu_of(s, x);
    return e;
  endfunction

  function automatic ex_t next_of(ex_t s, in_t x);
    ex_t n;
    n = '{valid: 1'b0, rsd: 32'd0, rtd: 32'd0, imm: 32'd0, shamt: 5'd0, rs: 5'd0, rt: 5'd0,
          rd: 5'd0, fun: 6'd0, sign: 1'b0, s1: 1'b0, s2: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
    if (x.reset) return n;
    if (x.stall) begin
      n = s;
      if (writes(x.ww, x.wrd, s.rs)) n.rsd = x.wres;
      if (writes(x.ww, x.wrd, s.rt)) n.rtd = x.wres;
      return n;
    end
    if (x.flush || lu_of(s, x)) return n;
    n.valid = x.idv; n.imm = x.imm; n.shamt = x.shamt; n.rs = x.rs; n.rt = x.rt; n.rd = x.rd;
    n.fun = x.fun; n.sign = x.sign; n.s1 = x.s1; n.s2 = x.s2;
    n.rw = x.rw; n.mr = x.mr; n.mw = x.mw;
    n.rsd = writes(x.ww, x.wrd, x.rs) ? x.wres : x.rsd;
    n.rtd = writes(x.ww, x.wrd, x.rt) ? x.wres : x.rtd;
    return n;
  endfunction

  function automatic in_t idle();
    in_t x;
    x = '{reset: 1'b0, stall: 1'b0, flush: 1'b0, idv: 1'b0, rsd: 32'd0, rtd: 32'd0,
          imm: 32'd0, shamt: 5'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, fun: ALU_ADD, sign: 1'b0,
          s1: 1'b0, s2: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, xw: 1'b0, xrd: 5'd0,
          xres: 32'd0, ww: 1'b0, wrd: 5'd0, wres: 32'd0};
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x = idle();
    x.reset = ($urandom_range(0, 63) == 0);
    x.stall = ($urandom_range(0, 5) == 0);
    x.flush = ($urandom_range(0, 7) == 0);
    x.idv   = ($urandom_range(0, 7) != 0);
    x.rsd = $urandom; x.rtd = $urandom; x.imm = $urandom;
    x.shamt = 5'($urandom); x.fun = 6'($urandom); x.sign = 1'($urandom);
    x.rs = 5'($urandom_range(0, 7)); x.rt = 5'($urandom_range(0, 7));
    x.rd = 5'($urandom_range(0, 7));
    x.s1 = ($urandom_range(0, 3) == 0); x.s2 = ($urandom_range(0, 2) == 0);
    x.rw = 1'($urandom); x.mr = ($urandom_range(0, 2) == 0); x.mw = 1'($urandom);
    x.xw = 1'($urandom); x.xrd = 5'($urandom_range(0, 7)); x.xres = $urandom;
    x.ww = 1'($urandom); x.wrd = 5'($urandom_range(0, 7)); x.wres = $urandom;
    return x;
  endfunction

  task automatic apply(in_t x);
    reset              = x.reset;
    bus.stall_i        = x.stall;  bus.flush_i      = x.flush;  bus.id_valid    = x.idv;
    bus.id_rs_data     = x.rsd;    bus.id_rt_data   = x.rtd;    bus.id_imm32    = x.imm;
    bus.id_shamt       = x.shamt;  bus.id_rs        = x.rs;     bus.id_rt       = x.rt;
    bus.id_rd          = x.rd;     bus.id_ALUFun    = x.fun;    bus.id_Sign     = x.sign;
    bus.id_ALUSrc1     = x.s1;     bus.id_ALUSrc2   = x.s2;     bus.id_RegWrite = x.rw;
    bus.id_MemRead     = x.mr;     bus.id_MemWrite  = x.mw;
    bus.exmem_RegWrite = x.xw;     bus.exmem_rd     = x.xrd;    bus.exmem_result = x.xres;
    bus.memwb_RegWrite = x.ww;     bus.memwb_rd     = x.wrd;    bus.memwb_result = x.wres;
  endtask

  // Drive one cycle: inputs settle post-edge, prediction is queued, model advances at the edge.
  task automatic step(in_t x);
    apply(x);
    if (m_known) sb.push_back(expect_of(m, x));
    @(posedge clk);
    m = next_of(m, x);
    m_known = 1'b1;
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ex_valid",    32'(bus.ex_valid),    32'(e.valid));
      chk("ALU_A",       bus.ALU_A,            e.a);
      chk("ALU_B",       bus.ALU_B,            e.b);
      chk("store_data",  bus.ex_store_data,    e.store);
      chk("ALUFun",      32'(bus.ALUFun),      32'(e.fun));
      chk("Sign",        32'(bus.Sign),        32'(e.sign));
      chk("ex_rd",       32'(bus.ex_rd),       32'(e.rd));
      chk("ex_RegWrite", 32'(bus.ex_RegWrite), 32'(e.rw));
      chk("ex_MemRead",  32'(bus.ex_MemRead),  32'(e.mr));
      chk("ex_MemWrite", 32'(bus.ex_MemWrite), 32'(e.mw));
      chk("load_use",    32'(bus.load_use_o),  32'(e.lu));
    end
  end

  initial begin
    in_t x;
    // Reset while a valid instruction is presented; outputs must be zero afterwards.
    x = rand_in(); x.reset = 1'b1; x.idv = 1'b1; x.stall = 1'b0; step(x);
    x = rand_in(); x.reset = 1'b1; x.idv = 1'b1; x.stall = 1'b1; step(x);

    // ADD r3 then SUB r3: EX/MEM result must beat stale register data.
    x = idle(); x.idv = 1; x.rs = 1; x.rt = 2; x.rd = 3; x.rw = 1; x.fun = ALU_ADD; step(x);
    x = idle(); x.idv = 1; x.rs = 3; x.rt = 1; x.rd = 6; x.rw = 1; x.fun = ALU_SUB;
    x.rsd = 32'hDEAD_0003; step(x);
    x = idle(); x.xw = 1; x.xrd = 3; x.xres = 32'h0000_0010; step(x);

    // EX/MEM and MEM/WB both write r5: EX/MEM wins on ALU_B.
    x = idle(); x.idv = 1; x.rs = 1; x.rt = 5; x.rd = 2; step(x);
    x = idle(); x.xw = 1; x.xrd = 5; x.xres = 32'hAAAA; x.ww = 1; x.wrd = 5; x.wres = 32'hBBBB;
    step(x);

    // LW r4 then a reader of r4: one stall cycle, bubble, then re-capture.
    x = idle(); x.idv = 1; x.rs = 1; x.rd = 4; x.rw = 1; x.mr = 1; x.s2 = SRC2_IMM; step(x);
    x = idle(); x.idv = 1; x.rs = 4; x.rt = 2; x.rd = 7; x.rw = 1; step(x);
    step(x);
    x = idle(); step(x);

    // r0 writes on both paths must not forward.
    x = idle(); x.idv = 1; x.rs = 0; x.rt = 0; x.rd = 1; step(x);
    x = idle(); x.xw = 1; x.xrd = 0; x.xres = '1; x.ww = 1; x.wrd = 0; x.wres = '1; step(x);

    // Stall three cycles while MEM/WB refreshes held r7, release, then flush.
    x = idle(); x.idv = 1; x.rs = 7; x.rt = 3; x.rd = 2; x.rsd = 32'h5555; step(x);
    x = idle(); x.stall = 1; x.ww = 1; x.wrd = 7; x.wres = 32'h1234; step(x);
    x = idle(); x.stall = 1; x.flush = 1; step(x);
    x = idle(); x.stall = 1; step(x);
    x = idle(); x.idv = 1; x.rs = 2; x.rd = 3; x.flush = 1; step(x);
    x = idle(); x.idv = 1; x.rs = 2; x.rd = 3; step(x);

    for (int i = 0; i < 3000; i++) begin
      x = rand_in();
      step(x);
    end
    x = idle(); step(x);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
